// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, handler entry and field positions.
package cp0_exc_ctrl_pkg;

   localparam logic [4:0] CP0_COUNT   = 5'd9;
   localparam logic [4:0] CP0_COMPARE = 5'd11;
   localparam logic [4:0] CP0_SR      = 5'd12;
   localparam logic [4:0] CP0_CAUSE   = 5'd13;
   localparam logic [4:0] CP0_EPC     = 5'd14;
   localparam logic [4:0] CP0_PRID    = 5'd15;

   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;

   localparam int SR_IM_LSB     = 10;
   localparam int SR_EXL_BIT    = 1;
   localparam int SR_IE_BIT     = 0;
   localparam int CAUSE_BD_BIT  = 31;
   localparam int CAUSE_IP_LSB  = 10;
   localparam int CAUSE_EXC_LSB = 2;

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// CP0 Count/Compare timer; TI sets when Count becomes equal to Compare. Built only with CP0_TIMER_EN.
module cp0_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_count,
   input  logic        wr_compare,
   input  logic [31:0] wdata,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        ti
);

   logic [31:0] count_nxt;

   assign count_nxt = wr_count ? wdata : count + 32'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         compare <= '0;
         ti      <= 1'b0;
      end else begin
         count <= count_nxt;
         if (wr_compare) begin
            compare <= wdata;
            ti      <= 1'b0;
         end else if (count_nxt == compare) begin
            ti <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller at the M stage: SR, Cause, EPC, mfc0/mtc0, eret support.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_exc_ctrl
   import cp0_exc_ctrl_pkg::*;
#(
   parameter int          HWINT_W    = 6,
   parameter logic [31:0] PRID_VALUE = 32'h2025_0C07
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [4:0]         CP0Addr,
   input  logic [31:0]        CP0In,
   output logic [31:0]        CP0Out,
   input  logic [31:0]        VPC,
   input  logic               BDIn,
   input  logic [4:0]         ExcCodeIn,
   input  logic [HWINT_W-1:0] HWInt,
   input  logic               EXLClr,
   output logic [31:0]        EPCOut,
   output logic               Req
);

   logic [5:0]  im, ip;
   logic        exl, ie, bd;
   logic [4:0]  exc_code;
   logic [31:0] epc;
   logic [31:0] count_val, compare_val;
   logic        ti;
   logic [5:0]  hw_lines;
   logic        int_req, exc_req, wr_ok;
   logic [31:0] epc_target;

   assign wr_ok = en & ~Req;

`ifdef CP0_TIMER_EN
   cp0_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .wr_count  (wr_ok && (CP0Addr == CP0_COUNT)),
      .wr_compare(wr_ok && (CP0Addr == CP0_COMPARE)),
      .wdata     (CP0In),
      .count     (count_val),
      .compare   (compare_val),
      .ti        (ti)
   );
`else
   assign count_val   = '0;
   assign compare_val = '0;
   assign ti          = 1'b0;
`endif

   // Timer interrupt shares line 5 with the external input.
   assign hw_lines   = 6'(HWInt) | {ti, 5'b0};
   assign int_req    = (|(hw_lines & im)) & ie & ~exl;
   assign exc_req    = (ExcCodeIn != EXC_INT) & ~exl;
   assign Req        = int_req | exc_req;
   assign epc_target = {VPC[31:2], 2'b00} - (BDIn ? 32'd4 : 32'd0);
   assign EPCOut     = epc;

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         ip       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= hw_lines;
         if (Req) begin
            exl      <= 1'b1;
            exc_code <= int_req ? EXC_INT : ExcCodeIn;
            bd       <= BDIn;
            epc      <= epc_target;
         end else begin
            if (EXLClr)
               exl <= 1'b0;
            // mtc0 to SR is later in program order than the eret, so it overrides EXL.
            if (en && (CP0Addr == CP0_SR)) begin
               im  <= CP0In[SR_IM_LSB +: 6];
               exl <= CP0In[SR_EXL_BIT];
               ie  <= CP0In[SR_IE_BIT];
            end
            if (en && (CP0Addr == CP0_EPC))
               epc <= CP0In;
         end
      end
   end

   always_comb begin
      CP0Out = '0;
      case (CP0Addr)
         CP0_COUNT:   CP0Out = count_val;
         CP0_COMPARE: CP0Out = compare_val;
         CP0_SR:      CP0Out = {16'b0, im, 8'b0, exl, ie};
         CP0_CAUSE:   CP0Out = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
         CP0_EPC:     CP0Out = epc;
         CP0_PRID:    CP0Out = PRID_VALUE;
         default:     CP0Out = '0;
      endcase
   end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 block for the 5-stage MIPS core. Sits at the M stage and consumes the PC, BD flag and ExcCode carried by the E/M pipeline register.
- Decides whether to take an interrupt or exception, and raises Req. The pipeline uses Req to flush every stage register and redirect fetch to 0x0000_4180.
- Holds SR, Cause and EPC. Serves mfc0/mtc0 and supplies EPC for eret.

Parameters:
- HWINT_W, 6, number of external hardware interrupt lines; they map to IP[15:10].
- PRID_VALUE, 32'h2025_0C07, value returned when reading register 15 (PRId).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- en  in  1  mtc0 write enable, asserted while an mtc0 is in M
- CP0Addr  in  5  register number for mfc0/mtc0
- CP0In  in  32  mtc0 write data, after forwarding
- CP0Out  out  32  mfc0 read data, combinational
- VPC  in  32  PC of the instruction in M
- BDIn  in  1  instruction in M sits in a branch delay slot
- ExcCodeIn  in  5  pending exception code from M; 0 means none
- HWInt  in  HWINT_W  external interrupt lines, level-sensitive
- EXLClr  in  1  eret is in M
- EPCOut  out  32  current EPC register value, the eret target
- Req  out  1  take exception/interrupt this cycle, combinational

Behaviour:
- Registers and field layout:
  - SR (12): IM[15:10], EXL[1], IE[0].
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2].
  - EPC (14): full 32 bits.
  - All other SR/Cause bits read 0.
- Reset values: SR=0, Cause=0, EPC=0, so Req=0 and CP0Out=0 at Addr 0.
- Request logic (combinational):
  - IntReq = (|(HWInt & IM)) & IE & ~EXL.
  - ExcReq = (ExcCodeIn != 0) & ~EXL.
  - Req = IntReq | ExcReq.
- Priority: an interrupt beats a synchronous exception on the same cycle.
- On a clock edge with Req=1:
  - EXL <= 1.
  - Cause.ExcCode <= IntReq ? 5'd0 : ExcCodeIn.
  - Cause.BD <= BDIn.
  - EPC <= BDIn ? {VPC[31:2],2'b00} - 4 : {VPC[31:2],2'b00}.
- IP sampling: IP <= HWInt every cycle regardless of Req or EXL.
- mtc0: when en=1 and Req=0, the write takes effect at the edge.
  - Addr 12 writes IM, EXL and IE only.
  - Addr 14 writes EPC.
  - Addr 13 is read-only; writes are ignored.
  - Writes to any other address are ignored.
- EXLClr: with Req=0, EXL <= 0 at the edge.
- Simultaneous events:
  - Req beats mtc0 and EXLClr; the mtc0 is squashed.
  - mtc0 to SR in the same cycle as EXLClr: EXL takes the value written by mtc0, the later program-order write.
- Reads: CP0Out is a mux on CP0Addr.
  - 12, 13 and 14 return SR, Cause and EPC; 15 returns PRID_VALUE; any other address returns 0.
  - A read in the same cycle as a write returns the old value.
- EPCOut: always the EPC register. The pipeline handles the mtc0-EPC-then-eret hazard by stalling.
- Reset mid-operation: reset beats everything, including Req and en.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined:
  - Count (reg 9) increments every cycle and wraps 0xFFFF_FFFF -> 0.
  - Compare (reg 11) is writable.
  - TI is set on the edge where Count becomes equal to Compare, and is ORed into IP[15]/interrupt line 5.
  - A write to Compare clears TI.
  - A write to Count loads CP0In instead of incrementing.
  - Reset clears Count, Compare and TI.
- When undefined: registers 9 and 11 read 0, writes to them are ignored, and there is no timer interrupt.

Decomposition:
- Shared package/header holds:
  - CP0 register numbers: 9, 11, 12, 13, 14, 15.
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
  - Handler entry 32'h0000_4180.
  - Field bit positions for SR and Cause.
- Sub-module cp0_timer, instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset, then IM=6'h3F, IE=1; HWInt[2]=1 with VPC=0x3008 -> Req=1 same cycle; next cycle EPC=0x3008, ExcCode=0, EXL=1, Req=0.
- ExcCodeIn=12 (Ov), BDIn=1, VPC=0x300C, IE=0 -> Req=1; afterwards EPC=0x3008, Cause[31]=1, Cause[6:2]=12.
- EXL=1 with ExcCodeIn=10 and HWInt active -> Req stays 0; EXLClr=1 -> EXL=0 next cycle and the interrupt is taken the cycle after.
- mtc0 Addr=14, CP0In=0x3100 together with ExcCodeIn=8 -> write squashed; EPC=VPC and not 0x3100.
- mtc0 Addr=13, CP0In=0xFFFF_FFFF -> Cause unchanged. Addr=15 read -> 0x2025_0C07. Addr=7 read -> 0.
- CP0_TIMER_EN: Compare=5, IM[15]=1, IE=1 -> Req asserts when Count reaches 5; a write to Compare clears TI.
